// File: rtl/broadcast_scheduler.sv
// rtl/broadcast_scheduler.sv - round-robin activation broadcast scheduler with per-layer terminator and completion tracking
module broadcast_scheduler #(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = 6,
  parameter int DATA_W = 16,
  localparam int Q_W   = IDX_W + DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            layer_no,
  input  logic [NUM_PE-1:0]     req,
  input  logic [NUM_PE*Q_W-1:0] req_data,
  input  logic [NUM_PE-1:0]     req_last,
  output logic [NUM_PE-1:0]     grant,
  input  logic                  bcast_ready,
  output logic                  bcast_valid,
  output logic [Q_W-1:0]        bcast_data,
  input  logic [NUM_PE-1:0]     fin_comp,
  output logic                  comp_done,
  output logic [3:0]            layer_idx,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NUM_PE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BCAST    = 2'd1,
    TERM     = 2'd2,
    WAIT_FIN = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_PE-1:0] src_done;
  logic [NUM_PE-1:0] fin_seen;
  logic [3:0]        layer_no_q;

  logic [NUM_PE-1:0] pending;
  logic [NUM_PE-1:0] src_done_nxt;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  rr_nxt;
  logic [Q_W-1:0]    gnt_pkt;
  int                scan;

  logic seq_start;
  logic term_issue;
  logic fin_all;
  logic last_layer;
  logic complete;

  assign busy = (state != IDLE);

  // Round-robin pick among sources that still have packets for this layer
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    pending = req & ~src_done;
    if (state == BCAST && bcast_ready) begin
      for (int k = 0; k < NUM_PE; k++) begin
        scan = int'(rr_ptr) + k;
        if (scan >= NUM_PE) scan = scan - NUM_PE;
        if (!gnt_any && pending[scan]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(scan);
        end
      end
    end
    grant        = gnt_any ? (NUM_PE'(1) << gnt_idx) : '0;
    gnt_pkt      = req_data[int'(gnt_idx)*Q_W +: Q_W];
    rr_nxt       = (gnt_idx == PTR_W'(NUM_PE-1)) ? '0 : gnt_idx + 1'b1;
    src_done_nxt = src_done | (grant & req_last);
  end

  assign seq_start  = (state == IDLE) && start && (layer_no != 4'd0);
  assign term_issue = (state == TERM) && bcast_ready;
  assign fin_all    = &(fin_seen | fin_comp);
  assign complete   = (state == WAIT_FIN) && fin_all;
  assign last_layer = (layer_idx == layer_no_q - 4'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode for the layer sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (seq_start) state_nxt = BCAST;
      BCAST:    if (&src_done_nxt) state_nxt = TERM;
      TERM:     if (bcast_ready) state_nxt = WAIT_FIN;
      WAIT_FIN: if (fin_all) state_nxt = last_layer ? IDLE : BCAST;
      default:  state_nxt = IDLE;
    endcase
  end

  // Broadcast output, arbitration pointer and per-layer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_valid <= 1'b0;
      bcast_data  <= '0;
      comp_done   <= 1'b0;
      rr_ptr      <= '0;
      src_done    <= '0;
      fin_seen    <= '0;
      layer_idx   <= 4'd0;
      layer_no_q  <= 4'd0;
    end else begin
      bcast_valid <= 1'b0;
      bcast_data  <= '0;
      comp_done   <= 1'b0;
      if (gnt_any) begin
        rr_ptr   <= rr_nxt;
        src_done <= src_done_nxt;
        // zero-valued activations are popped from the source but never pushed to the PEs
        if (gnt_pkt[DATA_W-1:0] != '0) begin
          bcast_valid <= 1'b1;
          bcast_data  <= gnt_pkt;
        end
      end
      if (term_issue) bcast_valid <= 1'b1;
      if (state != IDLE) fin_seen <= fin_seen | fin_comp;
      if (seq_start) begin
        layer_idx  <= 4'd0;
        layer_no_q <= layer_no;
        src_done   <= '0;
        fin_seen   <= '0;
        rr_ptr     <= '0;
      end
      if (complete) begin
        comp_done <= 1'b1;
        fin_seen  <= '0;
        src_done  <= '0;
        if (!last_layer) layer_idx <= layer_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_broadcast_scheduler.sv
// tb/tb_broadcast_scheduler.sv - directed self-checking bench for broadcast_scheduler
module tb_broadcast_scheduler;

  localparam int NUM_PE = 4;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 16;
  localparam int Q_W    = IDX_W + DATA_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [3:0]            layer_no = 4'd0;
  logic [NUM_PE-1:0]     req = '0;
  logic [NUM_PE*Q_W-1:0] req_data = '0;
  logic [NUM_PE-1:0]     req_last = '0;
  logic [NUM_PE-1:0]     grant;
  logic                  bcast_ready = 1'b1;
  logic                  bcast_valid;
  logic [Q_W-1:0]        bcast_data;
  logic [NUM_PE-1:0]     fin_comp = '0;
  logic                  comp_done;
  logic [3:0]            layer_idx;
  logic                  busy;

  broadcast_scheduler #(.NUM_PE(NUM_PE), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_no(layer_no),
    .req(req), .req_data(req_data), .req_last(req_last), .grant(grant),
    .bcast_ready(bcast_ready), .bcast_valid(bcast_valid), .bcast_data(bcast_data),
    .fin_comp(fin_comp), .comp_done(comp_done), .layer_idx(layer_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // source packet stores
  logic [Q_W-1:0] sp [NUM_PE][16];
  logic           sl [NUM_PE][16];
  int             sn [NUM_PE];
  int             sh [NUM_PE];

  // observation logs
  int             glog [256];
  int             gcnt = 0;
  logic [Q_W-1:0] blog [256];
  int             bcnt = 0;
  int             term_cnt = 0;
  int             cd_cnt = 0;
  int             bad_idle = 0;
  int             bad_oh = 0;

  int             eg [$];
  logic [Q_W-1:0] eb [$];

  function automatic logic [Q_W-1:0] pk(input int idx, input int val);
    return {IDX_W'(idx), DATA_W'(val)};
  endfunction

  task automatic clr_src();
    for (int i = 0; i < NUM_PE; i++) begin
      sn[i] = 0;
      sh[i] = 0;
    end
  endtask

  task automatic push(input int i, input int idx, input int val, input logic last);
    sp[i][sn[i]] = pk(idx, val);
    sl[i][sn[i]] = last;
    sn[i]++;
  endtask

  // broadcast / completion monitor
  always @(negedge clk) begin
    if (bcast_valid) begin
      if (bcnt < 256) blog[bcnt] <= bcast_data;
      bcnt <= bcnt + 1;
      if (bcast_data == '0) term_cnt <= term_cnt + 1;
    end else if (bcast_data != '0) begin
      bad_idle <= bad_idle + 1;
    end
    if (comp_done) cd_cnt <= cd_cnt + 1;
  end

  // one clock: present source heads, sample grant, pop granted source
  task automatic step(input logic [NUM_PE-1:0] fin);
    for (int i = 0; i < NUM_PE; i++) begin
      if (sh[i] < sn[i]) begin
        req[i] = 1'b1;
        req_data[i*Q_W +: Q_W] = sp[i][sh[i]];
        req_last[i] = sl[i][sh[i]];
      end else begin
        req[i] = 1'b0;
        req_data[i*Q_W +: Q_W] = '0;
        req_last[i] = 1'b0;
      end
    end
    fin_comp = fin;
    #2;
    if ((grant & (grant - 1'b1)) != '0) bad_oh++;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant[i]) begin
        if (gcnt < 256) glog[gcnt] = i;
        gcnt++;
        sh[i]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    fin_comp = '0;
  endtask

  task automatic do_start(input logic [3:0] n);
    start = 1'b1;
    layer_no = n;
    step('0);
    start = 1'b0;
    layer_no = 4'd0;
  endtask

  task automatic wait_term(input string tag);
    int t0;
    t0 = term_cnt;
    for (int k = 0; k < 200 && term_cnt == t0; k++) step('0);
    check(tag, 32'(term_cnt - t0), 32'd1);
  endtask

  task automatic check_grants(input string tag, input int base);
    check({tag, "_gcount"}, 32'(gcnt - base), 32'(eg.size()));
    for (int j = 0; j < eg.size() && base + j < gcnt; j++)
      check(tag, 32'(glog[base+j]), 32'(eg[j]));
  endtask

  task automatic check_bcast(input string tag, input int base);
    check({tag, "_bcount"}, 32'(bcnt - base), 32'(eb.size()));
    for (int j = 0; j < eb.size() && base + j < bcnt; j++)
      check(tag, 32'(blog[base+j]), 32'(eb[j]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, bb, cd0, t0, gm, bm;

    // reset state with requests pending
    rst_n = 1'b0;
    req = '1;
    req_last = '1;
    req_data = {NUM_PE{pk(1, 1)}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bcast_valid), 32'd0);
    check("rst_data", 32'(bcast_data), 32'd0);
    check("rst_comp_done", 32'(comp_done), 32'd0);
    check("rst_layer_idx", 32'(layer_idx), 32'd0);
    rst_n = 1'b1;
    clr_src();
    step('0);

    // two packets per source, single layer
    clr_src();
    for (int i = 0; i < NUM_PE; i++)
      for (int k = 0; k < 2; k++) push(i, i*2+k+1, 256*(i+1)+k+1, k == 1);
    gb = gcnt; bb = bcnt; cd0 = cd_cnt;
    do_start(4'd1);
    check("t34_busy_run", 32'(busy), 32'd1);
    wait_term("t34_term");
    step('1);
    step('0);
    eg = '{0, 1, 2, 3, 0, 1, 2, 3};
    eb.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_PE; i++) eb.push_back(pk(i*2+k+1, 256*(i+1)+k+1));
    eb.push_back('0);
    check_grants("t34_grant", gb);
    check_bcast("t34_bcast", bb);
    check("t34_comp_done", 32'(cd_cnt - cd0), 32'd1);
    check("t34_busy_end", 32'(busy), 32'd0);

    // back-pressure during BCAST and during TERM
    clr_src();
    for (int i = 0; i < NUM_PE; i++)
      for (int k = 0; k < 2; k++) push(i, i*2+k+1, 256*(i+1)+k+1, k == 1);
    gb = gcnt; bb = bcnt; cd0 = cd_cnt;
    do_start(4'd1);
    repeat (3) step('0);
    gm = gcnt; bm = bcnt;
    bcast_ready = 1'b0;
    repeat (5) step('0);
    check("t35_stall_grants", 32'(gcnt - gm), 32'd0);
    check("t35_stall_valid", 32'(bcnt - bm), 32'd0);
    bcast_ready = 1'b1;
    for (int k = 0; k < 50 && gcnt - gb < 8; k++) step('0);
    t0 = term_cnt;
    bcast_ready = 1'b0;
    repeat (5) step('0);
    check("t35_term_stall", 32'(term_cnt - t0), 32'd0);
    bcast_ready = 1'b1;
    wait_term("t35_term");
    step('1);
    step('0);
    check_grants("t35_grant", gb);
    check_bcast("t35_bcast", bb);
    check("t35_comp_done", 32'(cd_cnt - cd0), 32'd1);

    // zero-valued packet from source 2, plus start while busy
    clr_src();
    push(0, 1, 16'h0011, 1'b1);
    push(1, 2, 16'h0022, 1'b1);
    push(2, 5, 16'h0000, 1'b1);
    push(3, 7, 16'h0077, 1'b1);
    gb = gcnt; bb = bcnt; cd0 = cd_cnt;
    do_start(4'd1);
    do_start(4'd5);
    check("t38_layer_idx_busy", 32'(layer_idx), 32'd0);
    wait_term("t36_term");
    step('1);
    step('0);
    eg = '{0, 1, 2, 3};
    eb = '{pk(1, 16'h0011), pk(2, 16'h0022), pk(7, 16'h0077), '0};
    check_grants("t36_grant", gb);
    check_bcast("t36_bcast", bb);
    check("t38_comp_done", 32'(cd_cnt - cd0), 32'd1);
    check("t38_busy_end", 32'(busy), 32'd0);
    bb = bcnt;
    do_start(4'd0);
    step('0);
    check("t38_zero_start_busy", 32'(busy), 32'd0);
    check("t38_zero_start_bcast", 32'(bcnt - bb), 32'd0);

    // three layers, staggered finish pulses, pointer persists across layers
    clr_src();
    push(0, 1, 16'h0101, 1'b0);
    push(0, 2, 16'h0102, 1'b1);
    push(0, 3, 16'h0103, 1'b1);
    push(0, 4, 16'h0104, 1'b1);
    for (int i = 1; i < NUM_PE; i++)
      for (int l = 0; l < 3; l++) push(i, 8+i*4+l, 16'h0200+i*16+l, 1'b1);
    gb = gcnt; bb = bcnt; cd0 = cd_cnt;
    do_start(4'd3);
    for (int l = 0; l < 3; l++) begin
      step(4'b0010);
      wait_term("t37_term");
      step(4'b0001);
      step(4'b0100);
      check("t37_no_early_done", 32'(cd_cnt - cd0), 32'(l));
      check("t37_layer_idx", 32'(layer_idx), 32'(l));
      step(4'b1000);
      check("t37_comp_done", 32'(cd_cnt - cd0), 32'(l + 1));
      check("t37_layer_next", 32'(layer_idx), (l == 2) ? 32'd2 : 32'(l + 1));
      check("t37_busy", 32'(busy), (l == 2) ? 32'd0 : 32'd1);
    end
    eg = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    check_grants("t37_grant", gb);
    check("t37_bcount", 32'(bcnt - bb), 32'd16);

    // reset asserted mid-cycle while waiting for the last PE
    clr_src();
    for (int i = 0; i < NUM_PE; i++)
      for (int k = 0; k < 2; k++) push(i, 40+i*2+k, 16'h0300+i*2+k, 1'b1);
    do_start(4'd2);
    wait_term("t39_term0");
    step('1);
    wait_term("t39_term1");
    step(4'b0111);
    step('0);
    check("t39_layer_pre", 32'(layer_idx), 32'd1);
    check("t39_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req = '1;
    req_last = '1;
    req_data = {NUM_PE{pk(9, 9)}};
    #1;
    check("t39_rst_grant", 32'(grant), 32'd0);
    check("t39_rst_busy", 32'(busy), 32'd0);
    check("t39_rst_layer", 32'(layer_idx), 32'd0);
    check("t39_rst_valid", 32'(bcast_valid), 32'd0);
    check("t39_rst_data", 32'(bcast_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t39_rst_comp_done", 32'(comp_done), 32'd0);
    rst_n = 1'b1;
    clr_src();
    cd0 = cd_cnt; t0 = term_cnt;
    step(4'b1000);
    repeat (3) step('0);
    check("t39_no_comp_done", 32'(cd_cnt - cd0), 32'd0);
    check("t39_no_term", 32'(term_cnt - t0), 32'd0);
    check("t39_busy_post", 32'(busy), 32'd0);

    check("grant_onehot", 32'(bad_oh), 32'd0);
    check("idle_data_zero", 32'(bad_idle), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
